// File: rtl/spi_flash_master.sv
// SPI mode-0 master for a serial NOR flash. One request runs a full flash
// transaction: READ (0x03), or WREN (0x06) + PAGE PROGRAM (0x02) followed by
// RDSR (0x05) polling until the write-in-progress bit clears.
module spi_flash_master #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              sclk_o,
    output logic              csbar_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    localparam int unsigned FRAME_W = 8 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int unsigned POLL_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        StIdle, StRd, StWren, StPp, StPoll, StGap, StDone
    } state_e;

    state_e              state_q, state_d, gap_next_q, gap_next_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sclk_q, sclk_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;

    logic                in_frame, accept, div_end, load;
    logic [CNT_W-1:0]    last_idx;

    assign in_frame = (state_q == StRd) || (state_q == StWren) ||
                      (state_q == StPp) || (state_q == StPoll);
    assign accept   = (state_q == StIdle) && ready_q && (read_i || write_i);
    assign div_end  = (div_q == DIV_W'(CLK_DIV - 1));

    // Next-state logic: request capture, SCLK divider, shifting and sequencing.
    always_comb begin
        state_d       = state_q;
        gap_next_d    = gap_next_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        bit_d         = bit_q;
        div_d         = div_q;
        sclk_d        = sclk_q;
        gap_d         = gap_q;
        poll_d        = poll_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = err_q;
        // ready returns one cycle after the FSM is back in idle
        ready_d       = (state_q == StIdle) && !accept;
        load          = 1'b0;

        case (state_q)
            StWren:  last_idx = CNT_W'(7);
            StPoll:  last_idx = CNT_W'(15);
            default: last_idx = CNT_W'(FRAME_W - 1);
        endcase

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    err_d   = 1'b0;
                    poll_d  = '0;
                    load    = 1'b1;
                    state_d = read_i ? StRd : StWren;
                end
            end
            StRd, StWren, StPp, StPoll: begin
                div_d = div_q + DIV_W'(1);
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        // rising SCLK edge: sample MISO
                        rx_d = {rx_q[DATA_W-2:0], miso_i};
                    end else begin
                        // falling SCLK edge: present next MOSI bit
                        tx_d  = tx_q << 1;
                        bit_d = bit_q + CNT_W'(1);
                        if (bit_q == last_idx) begin
                            bit_d = '0;
                            case (state_q)
                                StRd: begin
                                    rdata_d       = rx_q;
                                    rdata_valid_d = 1'b1;
                                    state_d       = StDone;
                                end
                                StWren: begin
                                    gap_next_d = StPp;
                                    state_d    = StGap;
                                end
                                StPp: begin
                                    gap_next_d = StPoll;
                                    state_d    = StGap;
                                end
                                default: begin
                                    poll_d = poll_q + POLL_W'(1);
                                    if (!rx_q[0]) begin
                                        state_d = StDone;
                                    end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
                                        err_d   = 1'b1;
                                        state_d = StDone;
                                    end else begin
                                        gap_next_d = StPoll;
                                        state_d    = StGap;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
            StGap: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    gap_d   = '0;
                    load    = 1'b1;
                    state_d = gap_next_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Frame start: command and payload left-justified so MOSI is the MSB.
        if (load) begin
            div_d  = '0;
            sclk_d = 1'b0;
            bit_d  = '0;
            case (state_d)
                StRd:    tx_d = {8'h03, addr_i, {DATA_W{1'b0}}};
                StWren:  tx_d = {8'h06, {(FRAME_W - 8){1'b0}}};
                StPp:    tx_d = {8'h02, addr_q, wdata_q};
                StPoll:  tx_d = {8'h05, {(FRAME_W - 8){1'b0}}};
                default: tx_d = tx_q;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            gap_next_q    <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            bit_q         <= '0;
            div_q         <= '0;
            sclk_q        <= 1'b0;
            gap_q         <= '0;
            poll_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            gap_next_q    <= gap_next_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_q         <= bit_d;
            div_q         <= div_d;
            sclk_q        <= sclk_d;
            gap_q         <= gap_d;
            poll_q        <= poll_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
            ready_q       <= ready_d;
        end
    end

    // Pin outputs: SPI lines are forced idle outside a frame.
    always_comb begin
        csbar_o       = !in_frame;
        sclk_o        = in_frame && sclk_q;
        mosi_o        = in_frame && tx_q[FRAME_W-1];
        rdata_o       = rdata_q;
        rdata_valid_o = rdata_valid_q;
        ready_o       = ready_q;
        err_o         = err_q;
    end

endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
Parametrised SPI (mode 0) master for the off-chip serial NOR flash. It replaces the fixed 32/64-bit shift-and-count controller and has its own integrated shift registers, bit counter and SCLK divider. One request runs a full flash transaction:
- read: READ 0x03
- write: WREN 0x06, then PAGE PROGRAM 0x02, then RDSR 0x05 polling until WIP clears.

It sits between the processor-side memory-mapped IO port and the flash pins.

Parameters:
ADDR_W, 24, flash address width in bits; must be a multiple of 8.
DATA_W, 32, data word width in bits; must be a multiple of 8.
CLK_DIV, 2, clk cycles per SCLK half-period; must be at least 1.
CS_GAP, 4, minimum clk cycles CSbar stays high between frames.
POLL_MAX, 1023, maximum RDSR frames before a write reports an error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
read  in  1  read request; sampled only while ready=1
write  in  1  write request; sampled only while ready=1
addr  in  ADDR_W  flash byte address; captured with the request
wdata  in  DATA_W  write data; captured with the request
rdata  out  DATA_W  read data; held until the next read completes
rdata_valid  out  1  one-cycle pulse when rdata updates
ready  out  1  idle and able to accept a request
err  out  1  sticky; set on poll timeout, cleared by the next accepted request
sclk  out  1  SPI clock, idle low
CSbar  out  1  flash chip select, active low
mosi  out  1  serial data to flash, MSB first
miso  in  1  serial data from flash

Behaviour:
Reset:
- rst=0 at a clk edge forces state IDLE immediately, including mid-frame.
- Output values: CSbar=1, sclk=0, mosi=0, ready=1, rdata=0, rdata_valid=0, err=0.
- All counters are cleared.

Request acceptance:
- Requests are accepted in IDLE only. If read and write are both high, read wins.
- On acceptance, addr and wdata are latched. ready drops the next cycle and stays low until the cycle after the transaction returns to IDLE.

Frame timing:
- CSbar goes low in the cycle after acceptance, with the first MOSI bit already driven.
- sclk rises CLK_DIV cycles later and falls after a further CLK_DIV cycles. One bit therefore takes 2*CLK_DIV clk cycles.
- mosi changes only at sclk falling edges (and at frame start).
- miso is sampled on the clk edge where sclk rises.
- After the last falling edge, CSbar returns high in the same cycle.

States:
- IDLE
- RD: 8+ADDR_W+DATA_W bits. MOSI carries 0x03, then addr, then zeros. The last DATA_W sampled bits form rdata.
- WREN: 8 bits, 0x06.
- PP: 8+ADDR_W+DATA_W bits; 0x02, then addr, then wdata.
- POLL: 16 bits; 0x05, then 8 status bits are shifted in.
- GAP: CSbar high for exactly CS_GAP cycles, then advance to the next state.
- DONE: 1 cycle, then IDLE.

Transitions:
- IDLE→RD→DONE.
- IDLE→WREN→GAP→PP→GAP→POLL.
- POLL: if status[0]=1 and poll count < POLL_MAX, go GAP→POLL. If status[0]=0, go DONE. If the count reaches POLL_MAX with status[0] still 1, set err and go DONE.

Completion:
- rdata_valid pulses in DONE for reads only.
- The poll count resets on every accepted write.

Other rules:
- The bit counter width is clog2(8+ADDR_W+DATA_W+1) and it never wraps within a frame.
- read/write toggling while ready=0 is ignored.
- addr/wdata changes after acceptance have no effect.

Test Plan:
1. Reset mid-RD frame (rst=0 at bit 20) -> next cycle: CSbar=1, sclk=0, ready=1. A following read runs a clean full frame.
2. Read, defaults, addr=0x012345, flash model returns 0xDEADBEEF -> MOSI shows 0x03,0x012345 MSB first. CSbar is low for exactly 64*4=256 cycles. rdata=0xDEADBEEF with a single rdata_valid pulse. ready returns 2 cycles after CSbar rises.
3. Write addr=0x000100, wdata=0xA5A5A5A5, model WIP=1 for 3 polls -> frame sequence is WREN(8 bits), PP(64 bits), then 4 POLL frames. Each CSbar-high gap is exactly 4 cycles. err=0 and ready returns.
4. Poll timeout, POLL_MAX=3, WIP stuck at 1 -> exactly 3 POLL frames, then err=1 and ready=1. The next accepted read clears err.
5. read=write=1 in the same cycle -> a read frame (0x03) runs and the write is dropped. Requests pulsed while busy are ignored.
6. Parameter sweep, CLK_DIV=1, ADDR_W=32, DATA_W=8 -> read frame is 48 bits with sclk period of 2 clk cycles, and rdata captures the last 8 miso bits correctly.
